// File: rtl/hazard_scoreboard_unit_if.sv
// ID-stage hazard scoreboard bus: decode-side inputs and the stall controls
// driven back into the front end. Optional stall statistics: HAZARD_STATS_EN.
interface hazard_scoreboard_unit_if #(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned LAT_W       = 3,
    parameter int unsigned STALL_CNT_W = 32
);
    logic                   id_valid;
    logic [REG_ADDR_W-1:0]  id_rs1;
    logic [REG_ADDR_W-1:0]  id_rs2;
    logic                   id_use_rs1;
    logic                   id_use_rs2;
    logic [REG_ADDR_W-1:0]  id_rd;
    logic                   id_reg_write;
    logic [LAT_W-1:0]       id_latency;
    logic                   flush;
    logic                   is_hazard;
    logic                   IF_ID_inst_write;
    logic                   PCWrite;
    logic                   busy;
    logic [STALL_CNT_W-1:0] stall_count;

    // Decode stage / testbench side
    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_write, id_latency, flush,
        input  is_hazard, IF_ID_inst_write, PCWrite, busy, stall_count
    );

    // Scoreboard side
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_write, id_latency, flush,
        output is_hazard, IF_ID_inst_write, PCWrite, busy, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Per-register countdown scoreboard for in-flight writes of variable latency.
// Detects RAW and WAW hazards at ID and drives bubble / IF-ID / PC enables.
// Hazard outputs are combinational from registered counters (zero latency).
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
module hazard_scoreboard_unit #(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned LAT_W       = 3,
    parameter int unsigned STALL_CNT_W = 32
) (
    input logic                     clk,
    input logic                     reset,
    hazard_scoreboard_unit_if.slave sb
);
    localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;

    logic [LAT_W-1:0] cnt_q [NUM_REGS];
    logic [LAT_W-1:0] cnt_d [NUM_REGS];
    logic             raw_c;
    logic             waw_c;
    logic             hazard_c;
    logic             alloc_c;
    logic             busy_c;

    // Hazard detection from the current ID instruction against the scoreboard
    always_comb begin
        raw_c    = (sb.id_use_rs1 && (sb.id_rs1 != '0) && (cnt_q[sb.id_rs1] != '0)) ||
                   (sb.id_use_rs2 && (sb.id_rs2 != '0) && (cnt_q[sb.id_rs2] != '0));
        waw_c    = sb.id_reg_write && (sb.id_rd != '0) && (cnt_q[sb.id_rd] > sb.id_latency);
        hazard_c = sb.id_valid && !sb.flush && (raw_c || waw_c);
        alloc_c  = sb.id_valid && !sb.flush && !hazard_c && sb.id_reg_write;
    end

    // Next counter values: allocation wins over decrement, zero saturates
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if ((r != 0) && alloc_c && (sb.id_rd == REG_ADDR_W'(r))) begin
                cnt_d[r] = sb.id_latency;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - LAT_W'(1);
            end
        end
    end

    // Scoreboard busy when any write is still in flight
    always_comb begin
        busy_c = 1'b0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            busy_c = busy_c | (cnt_q[r] != '0);
        end
    end

    // Counter state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sb.is_hazard        = hazard_c;
    assign sb.IF_ID_inst_write = !hazard_c;
    assign sb.PCWrite          = !hazard_c;
    assign sb.busy             = busy_c;

`ifdef HAZARD_STATS_EN
    logic [STALL_CNT_W-1:0] stall_q;

    // Saturating count of stalled cycles, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (hazard_c && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_CNT_W'(1);
        end
    end

    assign sb.stall_count = stall_q;
`else
    assign sb.stall_count = STALL_CNT_W'(0);
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit: cycle-by-cycle vector table
// plus a hand-written asynchronous-reset-during-stall sequence.
module tb_hazard_scoreboard_unit;
    logic clk;
    logic reset;

    hazard_scoreboard_unit_if #(.REG_ADDR_W(5), .LAT_W(3), .STALL_CNT_W(32)) bus ();

    hazard_scoreboard_unit #(.REG_ADDR_W(5), .LAT_W(3), .STALL_CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       valid;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic [2:0] lat;
        logic       fl;
        logic       hz;
        logic       bsy;
    } vec_t;

    typedef struct {
        string       name;
        logic        hz;
        logic        bsy;
        logic [31:0] stalls;
    } exp_t;

    vec_t  vecs[$];
    exp_t  exp_q[$];
    int    checks;
    int    failures;
    int    exp_stalls;

    function automatic vec_t mk(string name, logic valid, logic [4:0] rs1, logic u1,
                                logic [4:0] rs2, logic u2, logic [4:0] rd, logic rw,
                                logic [2:0] lat, logic fl, logic hz, logic bsy);
        vec_t v;
        v.name = name; v.valid = valid; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.rd = rd; v.rw = rw; v.lat = lat; v.fl = fl; v.hz = hz; v.bsy = bsy;
        return v;
    endfunction

    function automatic logic [31:0] stall_exp();
`ifdef HAZARD_STATS_EN
        return 32'(exp_stalls);
`else
        return 32'd0;
`endif
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic check_outputs(exp_t e);
        check({e.name, ".is_hazard"}, 32'(bus.is_hazard), 32'(e.hz));
        check({e.name, ".IF_ID_inst_write"}, 32'(bus.IF_ID_inst_write), 32'(!e.hz));
        check({e.name, ".PCWrite"}, 32'(bus.PCWrite), 32'(!e.hz));
        check({e.name, ".busy"}, 32'(bus.busy), 32'(e.bsy));
        check({e.name, ".stall_count"}, bus.stall_count, e.stalls);
    endtask

    task automatic drive(vec_t v);
        bus.id_valid     = v.valid;
        bus.id_rs1       = v.rs1;
        bus.id_use_rs1   = v.u1;
        bus.id_rs2       = v.rs2;
        bus.id_use_rs2   = v.u2;
        bus.id_rd        = v.rd;
        bus.id_reg_write = v.rw;
        bus.id_latency   = v.lat;
        bus.flush        = v.fl;
    endtask

    // Drive one vector after the edge, check at the falling edge, track stalls
    task automatic run_vec(vec_t v);
        exp_t e;
        exp_t got_e;
        @(posedge clk);
        #1;
        drive(v);
        e.name = v.name; e.hz = v.hz; e.bsy = v.bsy; e.stalls = stall_exp();
        exp_q.push_back(e);
        @(negedge clk);
        got_e = exp_q.pop_front();
        check_outputs(got_e);
        if (v.hz) exp_stalls++;
    endtask

    initial begin
        exp_t e;
        vec_t idle;
        checks = 0; failures = 0; exp_stalls = 0;
        idle = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //         name          val rs1 u1 rs2 u2 rd rw lat fl  hz bsy
        vecs.push_back(mk("no_prior",    1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("load_r3",     1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0));
        vecs.push_back(mk("lu_stall",    1, 0, 0, 3, 1, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk("lu_go",       1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("mul_r7",      1, 0, 0, 0, 0, 7, 1, 4, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk("mul_use_stall", 1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk("mul_use_go",  1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("mul_r7b",     1, 0, 0, 0, 0, 7, 1, 4, 0, 0, 0));
        vecs.push_back(mk("use_r0",      1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("rs1_unused",  1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("rs2_r7",      1, 0, 0, 7, 1, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk("invalid_r7",  0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("drained",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("mul_r9",      1, 0, 0, 0, 0, 9, 1, 5, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk("waw_stall", 1, 0, 0, 0, 0, 9, 1, 0, 0, 1, 1));
        vecs.push_back(mk("waw_go",      1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0));
        vecs.push_back(mk("alu0_noalloc", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("mul_r10",     1, 0, 0, 0, 0, 10, 1, 3, 0, 0, 0));
        vecs.push_back(mk("waw_eq_ok",   1, 0, 0, 0, 0, 10, 1, 3, 0, 0, 1));
        vecs.push_back(mk("waw_shorter", 1, 0, 0, 0, 0, 10, 1, 2, 0, 1, 1));
        vecs.push_back(mk("waw_eq_ok2",  1, 0, 0, 0, 0, 10, 1, 2, 0, 0, 1));
        vecs.push_back(mk("r10_cnt2",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("r10_cnt1",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("r10_done",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("rd0_write",   1, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0));
        vecs.push_back(mk("rd0_noalloc", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("load_r3b",    1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0));
        vecs.push_back(mk("rs_same_st",  1, 3, 1, 3, 1, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk("rs_same_go",  1, 3, 1, 3, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("r3_lat3",     1, 0, 0, 0, 0, 3, 1, 3, 0, 0, 0));
        vecs.push_back(mk("r3_cnt3",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("flush_haz",   1, 3, 1, 0, 0, 4, 1, 1, 1, 0, 1));
        vecs.push_back(mk("r4_noalloc",  1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("r3_done",     1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("flush_write", 1, 0, 0, 0, 0, 5, 1, 2, 1, 0, 0));
        vecs.push_back(mk("flush_noal",  1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("max_lat_r12", 1, 0, 0, 0, 0, 12, 1, 7, 0, 0, 0));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk("max_lat_busy", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("max_lat_done", 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset state
        reset = 1'b0;
        drive(idle);
        repeat (2) @(posedge clk);
        @(negedge clk);
        e.name = "reset"; e.hz = 0; e.bsy = 0; e.stalls = 32'd0;
        check_outputs(e);
        reset = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset asserted mid-stall with cnt[7]=3 drops the stall at once
        run_vec(mk("rst_mul_r7", 1, 0, 0, 0, 0, 7, 1, 4, 0, 0, 0));
        run_vec(mk("rst_pre_st", 1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 1));
        @(posedge clk);
        #1;
        check("rst_mid.pre_hazard", 32'(bus.is_hazard), 32'd1);
        #1;
        reset = 1'b0;
        exp_stalls = 0;
        #1;
        e.name = "rst_mid"; e.hz = 0; e.bsy = 0; e.stalls = 32'd0;
        check_outputs(e);
        @(negedge clk);
        reset = 1'b1;
        run_vec(mk("rst_after", 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard bound on simulation time
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the single-load-use hazard detector.
- Holds a per-register countdown scoreboard of in-flight writes with variable result latency, covering loads, multi-cycle mul/div and future long ops.
- Sits at the ID stage and drives the IF/ID write-enable, PC write-enable and bubble-insert signals.
- Adds WAW protection and flush-aware allocation. The single-load-use detector has neither.

Parameters:
- REG_ADDR_W, 5, register-index width. Tracks 2**REG_ADDR_W registers; register 0 is never tracked.
- LAT_W, 3, latency-counter width. Maximum producer latency is 2**LAT_W-1.
- STALL_CNT_W, 32, width of the stall statistics counter. Used only with HAZARD_STATS_EN.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_rs1  in  REG_ADDR_W  source register 1 of the ID instruction.
- id_rs2  in  REG_ADDR_W  source register 2 of the ID instruction.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- id_rd  in  REG_ADDR_W  destination register of the ID instruction.
- id_reg_write  in  1  ID instruction writes rd.
- id_latency  in  LAT_W  cycles until the result is forwardable to an ID consumer. ALU=0, load=1, mul=N.
- flush  in  1  squash the ID instruction this cycle (branch/jump redirect).
- is_hazard  out  1  insert bubble into ID/EX.
- IF_ID_inst_write  out  1  IF/ID register write enable.
- PCWrite  out  1  PC write enable.
- busy  out  1  some scoreboard counter is nonzero.
- stall_count  out  STALL_CNT_W  cycles stalled. Valid only with HAZARD_STATS_EN.

Behaviour:
- State: cnt[r], LAT_W bits, for r = 1..2**REG_ADDR_W-1. cnt[0] is constant 0.
- Reset (reset=0, asynchronous):
  - all cnt cleared to 0; stall_count cleared to 0.
  - resulting outputs: is_hazard=0, IF_ID_inst_write=1, PCWrite=1, busy=0.
  - reset asserted mid-stall drops the stall immediately; no pending state survives.
- RAW term:
  - raw = (id_use_rs1 && id_rs1!=0 && cnt[id_rs1]!=0) || (the same condition for rs2).
- WAW term:
  - waw = id_reg_write && id_rd!=0 && cnt[id_rd] > id_latency.
  - This blocks a short op from completing before an older long op to the same rd.
- Hazard output:
  - is_hazard = id_valid && !flush && (raw || waw).
  - It is combinational from registered cnt and the current inputs: zero-cycle latency.
  - IF_ID_inst_write = !is_hazard; PCWrite = !is_hazard.
- Accept:
  - accept = id_valid && !flush && !is_hazard.
- Per-cycle counter update, evaluated for each r:
  - if accept && id_reg_write && id_rd==r && r!=0: cnt[r] <= id_latency. Allocation beats decrement in the same cycle.
  - else if cnt[r]!=0: cnt[r] <= cnt[r]-1.
  - else cnt[r] holds.
- id_latency=0 allocates nothing; the result is forwarded normally.
- A source with cnt=1 stalls this cycle and proceeds next cycle. This matches the classic one-bubble load-use.
- A stalled instruction never allocates. Allocation happens only on the cycle it is accepted.
- flush with a hazard pending: is_hazard=0, no allocation, and existing counters keep decrementing.
- rs1==rs2 is a single check with no double effect.
- id_rd==0 never allocates and never raises WAW.
- busy = OR of all cnt!=0, combinational.
- No wrap-around: counters saturate at 0. id_latency is bounded by its width.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: stall_count increments by 1 on each clock edge where is_hazard=1 and saturates at all-ones. It is cleared only by reset.
- Undefined: no counter logic is built and stall_count is tied to 0.

Test Plan:
- Reset, then id_valid=1, rs1=5, use_rs1=1, no prior writes -> is_hazard=0, PCWrite=1, IF_ID_inst_write=1, busy=0.
- Load issue: rd=3, latency=1, accepted. Next cycle consumer with rs2=3, use_rs2=1 -> is_hazard=1 for exactly 1 cycle, then 0. stall_count=1 with the macro.
- Mul issue: rd=7, latency=4. Next cycle consumer with rs1=7 -> is_hazard high 4 consecutive cycles, low on the 5th. Consumer with rs1=0 during that window -> no stall.
- WAW: mul rd=9, latency=5 accepted. Next cycle ALU rd=9, latency=0 -> stalls until cnt[9]=0, then accepted.
- Flush during hazard: consumer on rs1=3 while cnt[3]=2, flush=1 -> is_hazard=0, and a load in that slot with rd=4, latency=1 does not allocate (cnt[4] stays 0).
- Assert reset mid-stall with cnt[7]=3 -> outputs return immediately to is_hazard=0, busy=0. After release a consumer of r7 is not stalled.
